// File: rtl/serial_word_receiver.sv
// Serial-in/parallel-out word receiver with a one-entry valid/ready output register.
// Optional parity bit after each word when PARITY_CHECK_EN is defined.
module serial_word_receiver #(
    parameter int WIDTH      = 4,
    parameter bit ODD_PARITY = 1'b0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sin,
    input  logic                          sin_valid,
    input  logic                          lsb_first,
    input  logic                          clear,
    output logic [WIDTH-1:0]              dout,
    output logic                          dout_valid,
    input  logic                          dout_ready,
    output logic [$clog2(WIDTH+2)-1:0]    bit_cnt,
    output logic                          overrun,
    output logic                          parity_err
);

    localparam int CW = $clog2(WIDTH + 2);

    typedef enum logic [1:0] {StIdle, StRecv, StPar} state_t;

    state_t           state;
    logic [WIDTH-1:0] sr;
    logic             lsb_q;

    logic             lsb_sel;
    logic [WIDTH-1:0] sr_shift;
    logic             last_data;
    logic             complete;
    logic [WIDTH-1:0] word;

    // The first bit of a word uses the live lsb_first; later bits use the latched copy.
    always_comb begin
        lsb_sel   = (state == StIdle) ? lsb_first : lsb_q;
        sr_shift  = lsb_sel ? {sin, sr[WIDTH-1:1]} : {sr[WIDTH-2:0], sin};
        last_data = sin_valid && !clear && (state == StRecv) && (bit_cnt == CW'(WIDTH - 1));
`ifdef PARITY_CHECK_EN
        complete  = sin_valid && !clear && (state == StPar);
        word      = sr;
`else
        complete  = last_data;
        word      = sr_shift;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= StIdle;
            sr         <= '0;
            lsb_q      <= 1'b0;
            bit_cnt    <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            overrun    <= 1'b0;
`ifdef PARITY_CHECK_EN
            parity_err <= 1'b0;
`endif
        end else begin
            if (complete) begin
                if (!dout_valid || dout_ready) begin
                    dout       <= word;
                    dout_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (dout_valid && dout_ready) begin
                dout_valid <= 1'b0;
            end

            if (clear) begin
                sr      <= '0;
                bit_cnt <= '0;
                state   <= StIdle;
            end else if (sin_valid) begin
                unique case (state)
                    StIdle: begin
                        sr      <= sr_shift;
                        lsb_q   <= lsb_first;
                        bit_cnt <= CW'(1);
                        state   <= StRecv;
                    end
                    StRecv: begin
                        sr <= sr_shift;
                        if (last_data) begin
`ifdef PARITY_CHECK_EN
                            bit_cnt <= CW'(WIDTH);
                            state   <= StPar;
`else
                            bit_cnt <= '0;
                            state   <= StIdle;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + CW'(1);
                        end
                    end
                    StPar: begin
`ifdef PARITY_CHECK_EN
                        if ((^{sr, sin}) != ODD_PARITY) begin
                            parity_err <= 1'b1;
                        end
`endif
                        bit_cnt <= '0;
                        state   <= StIdle;
                    end
                    default: begin
                        bit_cnt <= '0;
                        state   <= StIdle;
                    end
                endcase
            end
        end
    end

`ifndef PARITY_CHECK_EN
    assign parity_err = ODD_PARITY && 1'b0;
`endif

endmodule

// File: tb/tb_serial_word_receiver.sv
// Table-driven bench for serial_word_receiver (WIDTH=4, parity feature disabled),
// plus a hand-written back-to-back sequence.
module tb_serial_word_receiver;

    localparam int WIDTH = 4;
    localparam int CW    = $clog2(WIDTH + 2);

    logic             clk = 1'b0;
    logic             rst, sin, sin_valid, lsb_first, clear, dout_ready;
    logic [WIDTH-1:0] dout;
    logic             dout_valid, overrun, parity_err;
    logic [CW-1:0]    bit_cnt;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       r, s, v, l, c, rdy;
        logic [3:0] d;
        logic       dv;
        logic [2:0] cnt;
        logic       ov;
    } vec_t;

    vec_t vecs[$];

    serial_word_receiver #(.WIDTH(WIDTH), .ODD_PARITY(1'b0)) dut (
        .clk       (clk),
        .rst       (rst),
        .sin       (sin),
        .sin_valid (sin_valid),
        .lsb_first (lsb_first),
        .clear     (clear),
        .dout      (dout),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .bit_cnt   (bit_cnt),
        .overrun   (overrun),
        .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    task automatic add(input logic r, s, v, l, c, rdy, input logic [3:0] d,
                       input logic dv, input logic [2:0] cnt, input logic ov);
        vec_t t;
        t.r = r; t.s = s; t.v = v; t.l = l; t.c = c; t.rdy = rdy;
        t.d = d; t.dv = dv; t.cnt = cnt; t.ov = ov;
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input int idx, input logic [7:0] act,
                         input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic step(input logic r, s, v, l, c, rdy);
        @(negedge clk);
        rst = r; sin = s; sin_valid = v; lsb_first = l; clear = c; dout_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; sin = 1'b0; sin_valid = 1'b0; lsb_first = 1'b0; clear = 1'b0;
        dout_ready = 1'b0;

        //  r s v l c rdy  dout   dv cnt ov
        add(1,0,0,0,0,0, 4'b0000,0,0,0);
        // MSB-first 1101
        add(0,1,1,0,0,0, 4'b0000,0,1,0);
        add(0,1,1,0,0,0, 4'b0000,0,2,0);
        add(0,0,1,0,0,0, 4'b0000,0,3,0);
        add(0,1,1,0,0,0, 4'b1101,1,0,0);
        add(0,0,0,0,0,1, 4'b1101,0,0,0);
        // LSB-first 1,0,1,1; lsb_first dropped mid-word must be ignored
        add(0,1,1,1,0,0, 4'b1101,0,1,0);
        add(0,0,1,0,0,0, 4'b1101,0,2,0);
        add(0,1,1,0,0,0, 4'b1101,0,3,0);
        add(0,1,1,0,0,0, 4'b1101,1,0,0);
        add(0,0,0,0,0,1, 4'b1101,0,0,0);
        // overrun: 1101 held, 0011 dropped, 0110 completes with ready
        add(0,1,1,0,0,0, 4'b1101,0,1,0);
        add(0,1,1,0,0,0, 4'b1101,0,2,0);
        add(0,0,1,0,0,0, 4'b1101,0,3,0);
        add(0,1,1,0,0,0, 4'b1101,1,0,0);
        add(0,0,1,0,0,0, 4'b1101,1,1,0);
        add(0,0,1,0,0,0, 4'b1101,1,2,0);
        add(0,1,1,0,0,0, 4'b1101,1,3,0);
        add(0,1,1,0,0,0, 4'b1101,1,0,1);
        add(0,0,1,0,0,0, 4'b1101,1,1,1);
        add(0,1,1,0,0,0, 4'b1101,1,2,1);
        add(0,1,1,0,0,0, 4'b1101,1,3,1);
        add(0,0,1,0,0,1, 4'b0110,1,0,1);
        add(0,0,0,0,0,1, 4'b0110,0,0,1);
        // clear aborts partial word
        add(0,1,1,0,0,0, 4'b0110,0,1,1);
        add(0,1,1,0,0,0, 4'b0110,0,2,1);
        add(0,0,0,0,1,0, 4'b0110,0,0,1);
        add(0,0,1,0,0,0, 4'b0110,0,1,1);
        add(0,1,1,0,0,0, 4'b0110,0,2,1);
        add(0,1,1,0,0,0, 4'b0110,0,3,1);
        add(0,1,1,0,0,0, 4'b0111,1,0,1);
        add(0,0,0,0,0,1, 4'b0111,0,0,1);
        // clear with strobe drops that bit
        add(0,1,1,0,1,0, 4'b0111,0,0,1);
        add(0,1,1,0,0,0, 4'b0111,0,1,1);
        add(0,0,1,0,0,0, 4'b0111,0,2,1);
        add(0,0,1,0,0,0, 4'b0111,0,3,1);
        add(0,1,1,0,0,0, 4'b1001,1,0,1);
        // clear leaves the holding register alone
        add(0,0,0,0,1,0, 4'b1001,1,0,1);
        // reset mid-word beats a strobe, then 1010 received cleanly
        add(0,1,1,0,0,0, 4'b1001,1,1,1);
        add(0,1,1,0,0,0, 4'b1001,1,2,1);
        add(0,1,1,0,0,0, 4'b1001,1,3,1);
        add(1,1,1,0,0,0, 4'b0000,0,0,0);
        add(0,1,1,0,0,0, 4'b0000,0,1,0);
        add(0,0,1,0,0,0, 4'b0000,0,2,0);
        add(0,1,1,0,0,0, 4'b0000,0,3,0);
        add(0,0,1,0,0,0, 4'b1010,1,0,0);

        foreach (vecs[i]) begin
            step(vecs[i].r, vecs[i].s, vecs[i].v, vecs[i].l, vecs[i].c, vecs[i].rdy);
            check("dout", i, {4'b0, dout}, {4'b0, vecs[i].d});
            check("dout_valid", i, {7'b0, dout_valid}, {7'b0, vecs[i].dv});
            check("bit_cnt", i, {5'b0, bit_cnt}, {5'b0, vecs[i].cnt});
            check("overrun", i, {7'b0, overrun}, {7'b0, vecs[i].ov});
            check("parity_err", i, {7'b0, parity_err}, 8'h00);
        end

        // Back-to-back LSB-first words with ready held high: 0011 then 1110.
        begin
            logic [3:0] a_bits, b_bits;
            int n;
            a_bits = 4'b0011;
            b_bits = 4'b1110;
            for (int k = 0; k < 4; k++) step(1'b0, a_bits[k], 1'b1, 1'b1, 1'b0, 1'b1);
            check("b2b_a_valid", 100, {7'b0, dout_valid}, 8'h01);
            check("b2b_a_dout", 100, {4'b0, dout}, {4'b0, a_bits});
            for (int k = 0; k < 4; k++) begin
                step(1'b0, b_bits[k], 1'b1, 1'b1, 1'b0, 1'b1);
                if (k == 0) check("b2b_drain", 101, {7'b0, dout_valid}, 8'h00);
                if (k == 0) check("b2b_cnt", 101, {5'b0, bit_cnt}, 8'h01);
            end
            n = 0;
            while (!dout_valid && n < 4) begin
                step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                n++;
            end
            check("b2b_b_latency", 102, n[7:0], 8'h00);
            check("b2b_b_dout", 102, {4'b0, dout}, {4'b0, b_bits});
            check("b2b_overrun", 102, {7'b0, overrun}, 8'h00);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
